// File: rtl/key_arb_pkg.sv
// Shared types and helpers for the push-button round-robin LED arbiter.
// Holds the FSM state enum, requester count/index width, the all-off LED
// pattern and the round-robin winner search.
package key_arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;
    localparam logic [NUM_REQ-1:0] LED_OFF = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_e;

    // First set bit of req, searching upward from ptr and wrapping 3->0.
    function automatic logic [IDX_W-1:0] rr_winner(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr
    );
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] win;
        logic             found;
        win   = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = ptr + IDX_W'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/led_decode_2to4_n.sv
// Active-low one-hot 2-to-4 decoder; all outputs high when disabled.
// Ports: en (active-high enable), idx (selected output), led_n (active-low).
module led_decode_2to4_n
    import key_arb_pkg::*;
(
    input  logic               en,
    input  logic [IDX_W-1:0]   idx,
    output logic [NUM_REQ-1:0] led_n
);

    always_comb begin
        led_n = LED_OFF;
        if (en) begin
            led_n[idx] = 1'b0;
        end
    end

endmodule

// File: rtl/key_rr_led_arbiter.sv
// Round-robin arbiter sharing 4 active-low LEDs among 4 push-button
// requesters. Each press latches a pending request; one requester is
// granted at a time for HOLD_CYCLES, followed by GAP_CYCLES of all-off.
// Optional build macro KEY_DEBOUNCE_EN inserts a per-bit debounce filter
// (DEB_CYCLES stable cycles) between the synchronizer and the edge detect.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   KEY[3:0]    : raw buttons, active-low, asynchronous
//   LED[3:0]    : active-low one-hot of the current grant
//   gnt_valid   : high while a grant is shown
//   gnt_idx     : index of current or last grant
//   pending     : latched unserved requests
module key_rr_led_arbiter
    import key_arb_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned GAP_CYCLES  = 5_000_000,
    parameter int unsigned DEB_CYCLES  = 1_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] KEY,
    output logic [NUM_REQ-1:0] LED,
    output logic               gnt_valid,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic [NUM_REQ-1:0] pending
);

    localparam int unsigned MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_HG > DEB_CYCLES) ? MAX_HG : DEB_CYCLES;
    localparam int unsigned TMR_W   = (MAX_CYC >= 2) ? $clog2(MAX_CYC) : 1;

    logic [NUM_REQ-1:0] key_s1;
    logic [NUM_REQ-1:0] key_s2;
    logic [NUM_REQ-1:0] key_lvl;
    logic [NUM_REQ-1:0] key_d;
    logic [NUM_REQ-1:0] press;

    state_e             state;
    state_e             state_n;
    logic [TMR_W-1:0]   timer;
    logic [TMR_W-1:0]   timer_n;
    logic [IDX_W-1:0]   gnt_idx_n;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   rr_ptr_n;
    logic [IDX_W-1:0]   win;
    logic [NUM_REQ-1:0] pend_clr;
    logic [NUM_REQ-1:0] pending_n;

    // Two-flop synchronizer for the asynchronous button pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1 <= LED_OFF;
            key_s2 <= LED_OFF;
        end else begin
            key_s1 <= KEY;
            key_s2 <= key_s1;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int unsigned DEB_W = (DEB_CYCLES >= 2) ? $clog2(DEB_CYCLES) : 1;

    logic [NUM_REQ-1:0] deb_lvl;
    logic [DEB_W-1:0]   deb_cnt [NUM_REQ];

    // Filtered level follows the synchronized level only after it has
    // differed for DEB_CYCLES consecutive cycles; any bounce restarts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_lvl <= LED_OFF;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (key_s2[i] != deb_lvl[i]) begin
                    if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
                        deb_lvl[i] <= key_s2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end

    assign key_lvl = deb_lvl;
`else
    assign key_lvl = key_s2;
`endif

    // Falling-edge (press) detect on the clean level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_d <= LED_OFF;
        end else begin
            key_d <= key_lvl;
        end
    end

    assign press     = key_d & ~key_lvl;
    assign win       = rr_winner(pending, rr_ptr);
    // A new press re-queues even when the same bit is being served.
    assign pending_n = (pending & ~pend_clr) | press;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            timer     <= '0;
            gnt_idx   <= '0;
            rr_ptr    <= '0;
            pending   <= '0;
            gnt_valid <= 1'b0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            gnt_idx   <= gnt_idx_n;
            rr_ptr    <= rr_ptr_n;
            pending   <= pending_n;
            // Registered view of GRANT so the LED decode only sees flops.
            gnt_valid <= (state == GRANT);
        end
    end

    // Next-state, timer and grant selection.
    always_comb begin
        state_n   = state;
        timer_n   = timer;
        gnt_idx_n = gnt_idx;
        rr_ptr_n  = rr_ptr;
        pend_clr  = '0;
        unique case (state)
            IDLE: begin
                if (pending != '0) begin
                    gnt_idx_n     = win;
                    pend_clr[win] = 1'b1;
                    rr_ptr_n      = win + IDX_W'(1);
                    timer_n       = TMR_W'(HOLD_CYCLES - 1);
                    state_n       = GRANT;
                end
            end
            GRANT: begin
                if (timer == '0) begin
                    if (GAP_CYCLES > 0) begin
                        timer_n = TMR_W'(GAP_CYCLES - 1);
                        state_n = GAP;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    timer_n = timer - TMR_W'(1);
                end
            end
            GAP: begin
                if (timer == '0) begin
                    state_n = IDLE;
                end else begin
                    timer_n = timer - TMR_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    led_decode_2to4_n u_led_decode (
        .en    (gnt_valid),
        .idx   (gnt_idx),
        .led_n (LED)
    );

endmodule
